// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: one request at a time, held until ack.
// The master drives the request fields; the slave returns ack and read data.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 byte/half/word load-store sequencer: start->done in 2 cycles plus memory wait cycles, TIMEOUT abort.
// No queuing: start is sampled only in IDLE; mem_req is held until mem_ack or timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [3:0]                op,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  load_store_unit_if.master         mem,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               load_data,
  output logic [1:0]                err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [31:0] shifted;
  logic [31:0] ext_data;

  always_comb begin
    illegal    = 1'b1;
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wd_calc    = 32'd0;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010: illegal = 1'b0;
      default:                   illegal = 1'b1;
    endcase
    case (op[1:0])
      2'b00: begin
        be_calc = 4'b0001 << addr[1:0];
        wd_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wd_calc    = {2{wdata[15:0]}};
      end
      default: begin
        misaligned = (addr[1:0] != 2'b00);
        be_calc    = 4'b1111;
        wd_calc    = wdata;
      end
    endcase
    if (!op[3]) wd_calc = 32'd0;
  end

  // Lane select: the shift moves the addressed byte/half down to bit 0.
  always_comb begin
    shifted  = mem.mem_rdata >> {lane_q, 3'b000};
    ext_data = 32'd0;
    case (op_q[2:0])
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ext_data = shifted;
      3'b100:  ext_data = {24'd0, shifted[7:0]};
      3'b101:  ext_data = {16'd0, shifted[15:0]};
      default: ext_data = 32'd0;
    endcase
    if (op_q[3]) ext_data = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (illegal || misaligned) ? DONE : ACCESS;
      ACCESS:  if (mem.mem_ack || cnt == LAST_CNT) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 8'd0;
      op_q      <= 4'd0;
      lane_q    <= 2'd0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      load_data <= 32'd0;
      err       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            lane_q  <= addr[1:0];
            we_q    <= op[3];
            be_q    <= be_calc;
            addr_q  <= {addr[31:2], 2'b00};
            wdata_q <= wd_calc;
            cnt     <= 8'd0;
            // Rejected requests finalise their result here since ACCESS is skipped.
            if (illegal) begin
              err       <= 2'b10;
              load_data <= 32'd0;
            end else if (misaligned) begin
              err       <= 2'b01;
              load_data <= 32'd0;
            end
          end
        end
        ACCESS: begin
          if (mem.mem_ack) begin
            err       <= 2'b00;
            load_data <= ext_data;
          end else if (cnt == LAST_CNT) begin
            err       <= 2'b11;
            load_data <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = (state == ACCESS);
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for loads, stores, rejects,
// timeout and mid-access reset.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  err;

  load_store_unit_if mem_bus();

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .mem       (mem_bus),
    .busy      (busy),
    .done      (done),
    .load_data (load_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          lat, nreq;
  logic        stable, post_idle, any_done;
  logic        we_s;
  logic [3:0]  be_s;
  logic [31:0] ad_s, wd_s, ld_s;
  logic [1:0]  err_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and play memory: ack on ACCESS cycle ack_after+1 (never if negative).
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_after, input logic [31:0] rd,
                        input bit hold);
    bit seen;
    op = o; addr = a; wdata = wd; start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    lat = 1; nreq = 0; stable = 1'b1; seen = 1'b0;
    we_s = 1'b0; be_s = 4'd0; ad_s = 32'd0; wd_s = 32'd0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (mem_bus.mem_req) begin
        nreq++;
        if (nreq == 1) begin
          we_s = mem_bus.mem_we; be_s = mem_bus.mem_be;
          ad_s = mem_bus.mem_addr; wd_s = mem_bus.mem_wdata;
        end else if (we_s !== mem_bus.mem_we || be_s !== mem_bus.mem_be ||
                     ad_s !== mem_bus.mem_addr || wd_s !== mem_bus.mem_wdata) begin
          stable = 1'b0;
        end
      end
      mem_bus.mem_ack   = mem_bus.mem_req && (ack_after >= 0) && (nreq == ack_after + 1);
      mem_bus.mem_rdata = rd;
      step();
      lat++;
    end
    mem_bus.mem_ack = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    ld_s  = load_data;
    err_s = err;
    step();
    post_idle = !done && !busy;
    start = 1'b0;
    step();
    post_idle = post_idle && !done && !busy;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(busy),              32'd0);
    check({tag, "_done"},      32'(done),              32'd0);
    check({tag, "_mem_req"},   32'(mem_bus.mem_req),   32'd0);
    check({tag, "_mem_we"},    32'(mem_bus.mem_we),    32'd0);
    check({tag, "_mem_be"},    32'(mem_bus.mem_be),    32'd0);
    check({tag, "_mem_addr"},  mem_bus.mem_addr,       32'd0);
    check({tag, "_mem_wdata"}, mem_bus.mem_wdata,      32'd0);
    check({tag, "_load_data"}, load_data,              32'd0);
    check({tag, "_err"},       32'(err),               32'd0);
  endtask

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // LB 0x103: lane 3 = 0x80 sign-extended
    run_op("lb", 4'b0000, 32'h0000_0103, 32'd0, 0, 32'h80FF_1234, 1'b0);
    check("lb_lat",  32'(lat),  32'd2);
    check("lb_nreq", 32'(nreq), 32'd1);
    check("lb_be",   32'(be_s), 32'b1000);
    check("lb_we",   32'(we_s), 32'd0);
    check("lb_addr", ad_s,      32'h0000_0100);
    check("lb_wd",   wd_s,      32'd0);
    check("lb_ld",   ld_s,      32'hFFFF_FF80);
    check("lb_err",  32'(err_s), 32'd0);
    check("lb_idle", 32'(post_idle), 32'd1);

    // SH 0x202 with 3 wait cycles
    run_op("sh", 4'b1001, 32'h0000_0202, 32'hDEAD_BEEF, 3, 32'h1111_1111, 1'b0);
    check("sh_lat",    32'(lat),    32'd5);
    check("sh_nreq",   32'(nreq),   32'd4);
    check("sh_we",     32'(we_s),   32'd1);
    check("sh_be",     32'(be_s),   32'b1100);
    check("sh_wd",     wd_s,        32'hBEEF_BEEF);
    check("sh_addr",   ad_s,        32'h0000_0200);
    check("sh_stable", 32'(stable), 32'd1);
    check("sh_ld",     ld_s,        32'd0);
    check("sh_err",    32'(err_s),  32'd0);

    run_op("sb", 4'b1000, 32'h0000_0001, 32'h1234_5678, 1, 32'd0, 1'b0);
    check("sb_be", 32'(be_s), 32'b0010);
    check("sb_wd", wd_s,      32'h7878_7878);
    check("sb_lat", 32'(lat), 32'd3);

    // start held high through DONE must not launch a second request
    run_op("sw", 4'b1010, 32'h0000_0008, 32'hA5A5_0F0F, 0, 32'd0, 1'b1);
    check("sw_be",   32'(be_s), 32'b1111);
    check("sw_wd",   wd_s,      32'hA5A5_0F0F);
    check("sw_idle", 32'(post_idle), 32'd1);

    run_op("lh", 4'b0001, 32'h0000_0012, 32'd0, 0, 32'h8001_7FFF, 1'b0);
    check("lh_be", 32'(be_s), 32'b1100);
    check("lh_ld", ld_s,      32'hFFFF_8001);

    run_op("lbu", 4'b0100, 32'h0000_0101, 32'd0, 2, 32'h0000_AB00, 1'b0);
    check("lbu_be", 32'(be_s), 32'b0010);
    check("lbu_ld", ld_s,      32'h0000_00AB);

    run_op("lw_mis", 4'b0010, 32'h0000_0006, 32'd0, 0, 32'd0, 1'b0);
    check("lw_mis_lat",  32'(lat),  32'd1);
    check("lw_mis_nreq", 32'(nreq), 32'd0);
    check("lw_mis_err",  32'(err_s), 32'd1);

    run_op("lh_mis", 4'b0101, 32'h0000_0003, 32'd0, 0, 32'd0, 1'b0);
    check("lh_mis_err", 32'(err_s), 32'd1);

    // illegal code with a misaligned address: illegal wins
    run_op("ill", 4'b0011, 32'h0000_0001, 32'd0, 0, 32'd0, 1'b0);
    check("ill_lat",  32'(lat),  32'd1);
    check("ill_nreq", 32'(nreq), 32'd0);
    check("ill_err",  32'(err_s), 32'd2);

    run_op("lbu2", 4'b0100, 32'h0000_0000, 32'd0, 0, 32'h0000_00C3, 1'b0);
    check("lbu2_ld", ld_s, 32'h0000_00C3);

    run_op("tmo", 4'b0101, 32'h0000_0010, 32'd0, -1, 32'hFFFF_FFFF, 1'b0);
    check("tmo_nreq", 32'(nreq),  32'd16);
    check("tmo_lat",  32'(lat),   32'd17);
    check("tmo_err",  32'(err_s), 32'd3);
    check("tmo_ld",   ld_s,       32'd0);

    // reset during the second ACCESS cycle
    op = 4'b0001; addr = 32'h0000_0020; start = 1'b1;
    step();
    start = 1'b0;
    check("rst_acc1_req", 32'(mem_bus.mem_req), 32'd1);
    step();
    check("rst_acc2_req", 32'(mem_bus.mem_req), 32'd1);
    rst_n = 1'b0;
    step();
    check_all_zero("midrst");
    rst_n = 1'b1;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h1234_5678;
    any_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      any_done = any_done | done | busy;
    end
    mem_bus.mem_ack = 1'b0;
    check("late_ack_ignored", 32'(any_done), 32'd0);

    run_op("lw", 4'b0010, 32'h0000_0040, 32'd0, 0, 32'hCAFE_F00D, 1'b0);
    check("lw_lat",  32'(lat),   32'd2);
    check("lw_addr", ad_s,       32'h0000_0040);
    check("lw_be",   32'(be_s),  32'b1111);
    check("lw_ld",   ld_s,       32'hCAFE_F00D);
    check("lw_err",  32'(err_s), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles to wait for mem_ack before aborting (range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse from the ALU stage; sampled only in IDLE.
REQ-005 SHALL have port op  input  4  {is_store, funct3}: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; all other codes illegal.
REQ-006 SHALL have port addr  input  32  effective address, i.e. the ALU result.
REQ-007 SHALL have port wdata  input  32  store data; low byte/half used for SB/SH.
REQ-008 SHALL have port mem_req  output  1  memory request, held until ack or abort.
REQ-009 SHALL have port mem_we  output  1  1 = write.
REQ-010 SHALL have port mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-011 SHALL have port mem_be  output  4  byte enables.
REQ-012 SHALL have port mem_wdata  output  32  lane-replicated store data.
REQ-013 SHALL have port mem_ack  input  1  memory completion, valid only while mem_req=1.
REQ-014 SHALL have port mem_rdata  input  32  read word, valid with mem_ack.
REQ-015 SHALL have port busy  output  1  1 in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port load_data  output  32  extended load result; held until next done.
REQ-018 SHALL have port err  output  2  00 ok, 01 misaligned, 10 illegal op, 11 timeout; valid with done, held until next done.

Function
REQ-019 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE, plus IDLE -> DONE for rejected requests.
REQ-020 SHALL, in IDLE with start=1, register op/addr/wdata; go to ACCESS if legal and aligned, else to DONE with err set (illegal op takes priority over misaligned).
REQ-021 SHALL treat halfword ops with addr[0]=1 and word ops with addr[1:0]!=0 as misaligned; a rejected request issues no mem_req.
REQ-022 SHALL drive mem_req=1 in every ACCESS cycle; mem_addr/mem_we/mem_be/mem_wdata stable for the whole ACCESS state.
REQ-023 SHALL set mem_be: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111; mem_be is identical for loads and stores.
REQ-024 SHALL set mem_wdata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata; loads 0.
REQ-025 SHALL, on mem_ack in ACCESS, capture mem_rdata and go to DONE; latency start->done = 2 cycles with same-cycle ack, +1 per wait cycle.
REQ-026 SHALL count ACCESS cycles; if TIMEOUT cycles elapse with no ack, drop mem_req and go to DONE with err=11 and load_data=0.
REQ-027 SHALL, in DONE, pulse done=1 for one cycle; loads select the lane by addr[1:0] and sign-extend (LB/LH) or zero-extend (LBU/LHU); stores and errors give load_data=0.
REQ-028 SHALL ignore start while busy=1; no queuing. start in the cycle DONE returns to IDLE is also ignored.
REQ-029 SHALL ignore mem_ack outside ACCESS.

Reset
REQ-030 SHALL, with rst_n=0 at a clock edge, force IDLE and clear the counter, mem_req, mem_we, mem_be, mem_wdata, mem_addr, busy, done, load_data and err to 0.
REQ-031 SHALL honour reset mid-ACCESS: mem_req=0 next cycle, no done pulse, and a late mem_ack is ignored.

Verification
REQ-032 SHALL verify: LB addr=0x103, mem_rdata=0x80FF_1234, ack same cycle -> mem_be=1000, done at start+2, load_data=0xFFFFFF80, err=00.
REQ-033 SHALL verify: SH addr=0x202, wdata=0xDEAD_BEEF, ack after 3 wait cycles -> mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, done at start+5.
REQ-034 SHALL verify: LW addr=0x0000_0006 -> no mem_req, done at start+1, err=01; op=0011 -> err=10.
REQ-035 SHALL verify: LHU addr=0x10, ack never arrives, TIMEOUT=16 -> mem_req for exactly 16 cycles, then done with err=11, load_data=0.
REQ-036 SHALL verify: rst_n=0 during the 2nd ACCESS cycle -> all outputs 0 next cycle, no done; ack arriving later is ignored; a new LW at 0x40 afterwards completes normally.
